// File: rtl/sobel_pkg.sv
// Shared constants and types for the sobel_filter result path.
// The UART transmitter state encoding lives here so checkers can decode it by name.
package sobel_pkg;

  localparam int IMG_W   = 28;
  localparam int PIX_W   = 5;
  localparam int KER_W   = 3;
  localparam int OUT_DIM = 26;
  localparam int OUT_W   = 8;

  localparam int RES_BITS  = OUT_DIM * OUT_DIM * OUT_W;
  localparam int NUM_BYTES = OUT_DIM * OUT_DIM;
  localparam int IDX_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A new byte can be taken in the last cycle of a stop bit,
// so back-to-back bytes leave no idle gap on the line.
module uart_tx_byte
  import sobel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Handshake: a byte transfers on a cycle where valid && ready; data must be
  // stable while valid is high, and valid may be held across non-ready cycles.
  // ready is high when idle or in the final cycle of the stop bit.
  assign ready = (state == IDLE) || ((state == STOP) && bit_end);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    if (state != IDLE) begin
      baud_n = bit_end ? '0 : baud_cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        if (valid) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
          shift_n = data;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (valid) begin
            state_n = START;
            bit_n   = '0;
            shift_n = data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line changes on the state edge
    if (state_n == START) begin
      tx_n = 1'b0;
    end else if (state_n == DATA) begin
      tx_n = shift_n[0];
    end else begin
      tx_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: rtl/sobel_result_uart_tx.sv
// Sends the flat sobel result vector over UART 8N1, byte 0 (res_vec[7:0]) first,
// as one start-triggered frame with busy/done status.
module sobel_result_uart_tx
  import sobel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = sobel_pkg::NUM_BYTES,
  parameter int RES_BITS     = sobel_pkg::RES_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RES_BITS-1:0] res_vec,
  output logic                tx,
  output logic                busy,
  output logic                done,
  output logic [9:0]          byte_idx
);

  if (NUM_BYTES < 1 || NUM_BYTES > 1024) begin : g_bad_num_bytes
    $error("sobel_result_uart_tx: NUM_BYTES must be in 1..1024");
  end
  if (RES_BITS != 8 * NUM_BYTES) begin : g_bad_res_bits
    $error("sobel_result_uart_tx: RES_BITS must equal 8*NUM_BYTES");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("sobel_result_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam logic [9:0] LAST_IDX = 10'(NUM_BYTES - 1);

  logic [9:0] next_idx;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  // While busy, valid is held high for the following byte so the transmitter
  // picks it up in the same cycle its stop bit ends.
  assign next_idx   = busy ? byte_idx + 10'd1 : 10'd0;
  assign byte_valid = busy ? (byte_idx != LAST_IDX) : start;

  always_comb begin
    byte_data = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (next_idx == 10'(k)) begin
        byte_data = res_vec[8*k +: 8];
      end
    end
  end

  // byte_ready while busy only occurs at the end of a stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          byte_idx <= '0;
        end
      end else if (byte_ready) begin
        if (byte_idx == LAST_IDX) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 10'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .data (byte_data),
    .valid(byte_valid),
    .ready(byte_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_sobel_result_uart_tx.sv
// Bench for sobel_result_uart_tx: a small 3-byte frame instance and a full-size
// 676-byte instance at 2 clocks per bit, decoded by one line monitor.
module tb_sobel_result_uart_tx;

  localparam int NB_B = 676;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [23:0] res_a;
  logic [5407:0] res_b;
  logic        txa, busya, donea;
  logic        txb, busyb, doneb;
  logic [9:0]  idxa, idxb;
  logic        sel;
  int          cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  int         exp_i_q[$];
  int         exp_done_q[$];

  sobel_result_uart_tx #(
    .CLKS_PER_BIT(4),
    .NUM_BYTES   (3),
    .RES_BITS    (24)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start_a),
    .res_vec (res_a),
    .tx      (txa),
    .busy    (busya),
    .done    (donea),
    .byte_idx(idxa)
  );

  sobel_result_uart_tx #(
    .CLKS_PER_BIT(2)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
    .res_vec (res_b),
    .tx      (txb),
    .busy    (busyb),
    .done    (doneb),
    .byte_idx(idxb)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b;
    if (sel) begin
      b = (k == NB_B - 1) ? 8'hA5 : 8'h00;
    end else begin
      case (k)
        0:       b = 8'h01;
        1:       b = 8'hC3;
        default: b = 8'h5A;
      endcase
    end
    return b;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; start is high for exactly one sampling edge.
  task automatic drive_start(input bit accept);
    int n, p, t0;
    n  = sel ? NB_B : 3;
    p  = sel ? 2 : 4;
    t0 = cyc;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    if (accept) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(exp_byte(k));
        exp_t_q.push_back(t0 + 1 + k * 10 * p);
        exp_i_q.push_back(k);
      end
      exp_done_q.push_back(t0 + 1 + n * 10 * p);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // scoreboard: UART line decoder and done monitor
  logic       mon_tx, mon_done;
  logic [9:0] mon_idx;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;

  assign mon_tx   = sel ? txb : txa;
  assign mon_done = sel ? doneb : donea;
  assign mon_idx  = sel ? idxb : idxa;

  always @(negedge clk) begin
    int p;
    p = sel ? 2 : 4;
    if (rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (mon_tx === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        mon_byte   = '0;
        if (exp_t_q.size() == 0) begin
          chk("start_q_size", exp_t_q.size(), 1);
        end else begin
          chk("start_cycle", cyc, exp_t_q.pop_front());
          chk("byte_idx", {22'd0, mon_idx}, exp_i_q.pop_front());
        end
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == p / 2) begin
        chk("start_bit", {31'd0, mon_tx}, 0);
      end else if (mon_cnt > p && mon_cnt < 9 * p && (mon_cnt % p) == p / 2) begin
        mon_byte[mon_cnt / p - 1] = mon_tx;
      end else if (mon_cnt == 9 * p + p / 2) begin
        chk("stop_bit", {31'd0, mon_tx}, 1);
        if (exp_q.size() == 0) chk("byte_q_size", exp_q.size(), 1);
        else chk("byte_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        mon_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_done === 1'b1) begin
      if (exp_done_q.size() == 0) chk("done_q_size", exp_done_q.size(), 1);
      else chk("done_cycle", cyc, exp_done_q.pop_front());
      chk("busy_at_done", {31'd0, sel ? busyb : busya}, 0);
    end
  end

  task automatic chk_drained(input string tag);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_done_left"}, exp_done_q.size(), 0);
  endtask

  initial begin
    int t0;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sel     = 1'b0;
    res_a   = 24'h5AC301;
    res_b   = '0;
    res_b[5407:5400] = 8'hA5;

    // reset and idle line
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, txa}, 1);
    chk("rst_busy", {31'd0, busya}, 0);
    chk("rst_done", {31'd0, donea}, 0);
    chk("rst_idx", {22'd0, idxa}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_tx", {31'd0, txa}, 1);
      chk("idle_busy", {31'd0, busya}, 0);
    end

    // basic frame with busy window
    t0 = cyc;
    drive_start(1'b1);
    chk("busy_first", {31'd0, busya}, 1);
    wait_until(t0 + 120);
    chk("busy_last", {31'd0, busya}, 1);
    wait_until(t0 + 122);
    chk("post_busy", {31'd0, busya}, 0);
    chk("post_tx", {31'd0, txa}, 1);
    chk("post_idx", {22'd0, idxa}, 0);
    chk_drained("frame1");

    // start while busy is ignored
    wait_until(cyc + 3);
    t0 = cyc;
    drive_start(1'b1);
    wait_until(t0 + 50);
    drive_start(1'b0);
    wait_until(t0 + 130);
    chk_drained("ignored_start");

    // reset mid-frame, then a fresh frame
    t0 = cyc;
    drive_start(1'b1);
    wait_until(t0 + 30);
    rst = 1'b1;
    #1;
    chk("midrst_tx", {31'd0, txa}, 1);
    chk("midrst_busy", {31'd0, busya}, 0);
    chk("midrst_idx", {22'd0, idxa}, 0);
    exp_q.delete();
    exp_t_q.delete();
    exp_i_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("after_rst_tx", {31'd0, txa}, 1);
    t0 = cyc;
    drive_start(1'b1);
    wait_until(t0 + 125);
    chk_drained("after_rst");

    // start in the done cycle chains a second frame
    t0 = cyc;
    drive_start(1'b1);
    wait_until(t0 + 121);
    chk("done_seen", {31'd0, donea}, 1);
    drive_start(1'b1);
    wait_until(t0 + 121 + 125);
    chk_drained("chained");

    // full-size frame: only the last byte is non-zero
    sel = 1'b1;
    @(negedge clk);
    chk("b_idle_tx", {31'd0, txb}, 1);
    t0 = cyc;
    drive_start(1'b1);
    wait_until(t0 + 1 + NB_B * 20 + 4);
    chk("b_busy_end", {31'd0, busyb}, 0);
    chk_drained("full_frame");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
